// File: rtl/bcd_conv_if.sv
// Bus between the requesters and the shared binary-to-BCD converter.
//
// Signals:
//   req       requester -> converter  per-requester level request
//   bin_in    requester -> converter  flattened 8-bit values, slot i at [8i+7:8i]
//   grant     converter -> requester  one-hot grant, high for the whole service window
//   busy      converter -> requester  converter is not idle
//   out_valid converter -> display    one-cycle result strobe
//   out_id    converter -> display    requester index of the presented result
//   hundreds  converter -> display    BCD hundreds digit (0..2)
//   tens      converter -> display    BCD tens digit
//   ones      converter -> display    BCD ones digit
//
// Modports: master = requester/display side, slave = converter side.
interface bcd_conv_if #(
    parameter int NREQ = 4
) ();
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] bin_in;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic              out_valid;
    logic [1:0]        out_id;
    logic [3:0]        hundreds;
    logic [3:0]        tens;
    logic [3:0]        ones;

    modport master (
        output req, bin_in,
        input  grant, busy, out_valid, out_id, hundreds, tens, ones
    );

    modport slave (
        input  req, bin_in,
        output grant, busy, out_valid, out_id, hundreds, tens, ones
    );
endinterface

// File: rtl/bcd_conv_arbiter.sv
// Shared iterative (double-dabble) 8-bit binary-to-BCD converter with a
// round-robin arbiter in front of it. One requester is served at a time; a
// conversion takes 8 shift clocks plus one result cycle, and the arbiter
// re-arms one clock later, so the engine sustains one result per 10 clocks.
//
// Ports:
//   clk     system clock, all state updates on the rising edge
//   resetn  asynchronous active-low reset; aborts any conversion in flight
//   bus     bcd_conv_if.slave: req/bin_in in, grant/busy/out_valid/out_id
//           and the three BCD digits out
module bcd_conv_arbiter #(
    parameter int NREQ = 4
) (
    input  logic          clk,
    input  logic          resetn,
    bcd_conv_if.slave     bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [NREQ-1:0] ONE_HOT_0 = {{(NREQ-1){1'b0}}, 1'b1};

    logic [1:0]      state;
    logic [NREQ-1:0] grant_r;
    logic [1:0]      ptr;
    logic [1:0]      id;
    logic [2:0]      cnt;
    logic [7:0]      val;
    logic [3:0]      dig_h;
    logic [3:0]      dig_t;
    logic [3:0]      dig_o;

    logic [3:0]      hund_r;
    logic [3:0]      tens_r;
    logic [3:0]      ones_r;
    logic [1:0]      out_id_r;
    logic            out_valid_r;

    logic            sel_found;
    logic [1:0]      sel_idx;
    logic [2:0]      cand;
    logic [19:0]     adj;
    logic [19:0]     shifted;

    // Double-dabble correction: a digit of 5 or more becomes >= 8 after the
    // add, so the following shift carries it into the next decade.
    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    // Round-robin pick: first asserted req scanning upward from ptr, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = 2'd0;
        cand      = 3'd0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + 3'(k);
            if (cand >= 3'(NREQ)) begin
                cand = cand - 3'(NREQ);
            end
            if (!sel_found && bus.req[cand[1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[1:0];
            end
        end
    end

    // One iteration: correct every digit, then shift the whole
    // {hundreds, tens, ones, value} word left, pulling the value in MSB first.
    always_comb begin
        adj     = {add3(dig_h), add3(dig_t), add3(dig_o), val};
        shifted = adj << 1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            grant_r     <= '0;
            ptr         <= 2'd0;
            id          <= 2'd0;
            cnt         <= 3'd0;
            val         <= 8'd0;
            dig_h       <= 4'd0;
            dig_t       <= 4'd0;
            dig_o       <= 4'd0;
            hund_r      <= 4'd0;
            tens_r      <= 4'd0;
            ones_r      <= 4'd0;
            out_id_r    <= 2'd0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        grant_r <= ONE_HOT_0 << sel_idx;
                        val     <= bus.bin_in[{sel_idx, 3'b000} +: 8];
                        id      <= sel_idx;
                        dig_h   <= 4'd0;
                        dig_t   <= 4'd0;
                        dig_o   <= 4'd0;
                        cnt     <= 3'd0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    {dig_h, dig_t, dig_o, val} <= shifted;
                    cnt <= cnt + 3'd1;
                    // Eighth iteration: publish the finished digits directly
                    // from the shift result so they are valid in DONE.
                    if (cnt == 3'd7) begin
                        state       <= DONE;
                        hund_r      <= shifted[19:16];
                        tens_r      <= shifted[15:12];
                        ones_r      <= shifted[11:8];
                        out_id_r    <= id;
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    grant_r     <= '0;
                    out_valid_r <= 1'b0;
                    ptr         <= (id == 2'(NREQ - 1)) ? 2'd0 : id + 2'd1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant     = grant_r;
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.out_id    = out_id_r;
    assign bus.hundreds  = hund_r;
    assign bus.tens      = tens_r;
    assign bus.ones      = ones_r;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Self-checking bench for bcd_conv_arbiter. A timer-based reference model
// predicts grant/busy/strobe/result every cycle from the arbitration rules and
// decimal arithmetic; directed scenarios add literal expectations.
module tb_bcd_conv_arbiter;
    localparam int NREQ = 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    bcd_conv_if #(.NREQ(NREQ)) bus ();

    bcd_conv_arbiter #(.NREQ(NREQ)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: m_t = clocks since grant (0 = idle). Grant is seen at
    // m_t=1..9, the result strobe at m_t=9, then idle with pointer advanced.
    int m_t, m_id, m_val, m_ptr, m_h, m_d, m_o, m_oid;
    int m_c;
    bit m_found;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_t <= 0; m_id <= 0; m_val <= 0; m_ptr <= 0;
            m_h <= 0; m_d <= 0; m_o <= 0; m_oid <= 0;
        end else if (m_t == 9) begin
            m_t   <= 0;
            m_ptr <= (m_id + 1) % NREQ;
        end else if (m_t == 8) begin
            m_t   <= 9;
            m_h   <= m_val / 100;
            m_d   <= (m_val / 10) % 10;
            m_o   <= m_val % 10;
            m_oid <= m_id;
        end else if (m_t > 0) begin
            m_t <= m_t + 1;
        end else begin
            m_found = 1'b0;
            for (int k = 0; k < NREQ; k++) begin
                m_c = (m_ptr + k) % NREQ;
                if (!m_found && bus.req[m_c]) begin
                    m_found = 1'b1;
                    m_id  <= m_c;
                    m_val <= int'(bus.bin_in[8*m_c +: 8]);
                    m_t   <= 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("grant",     int'(bus.grant),     (m_t != 0) ? (1 << m_id) : 0);
        chk("busy",      int'(bus.busy),      (m_t != 0) ? 1 : 0);
        chk("out_valid", int'(bus.out_valid), (m_t == 9) ? 1 : 0);
        chk("out_id",    int'(bus.out_id),    m_oid);
        chk("hundreds",  int'(bus.hundreds),  m_h);
        chk("tens",      int'(bus.tens),      m_d);
        chk("ones",      int'(bus.ones),      m_o);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic wait_grant(input int ch);
        int ok = 0;
        for (int i = 0; i < 40 && ok == 0; i++) begin
            tick();
            if (bus.grant[ch]) ok = 1;
        end
        chk($sformatf("grant_seen_ch%0d", ch), ok, 1);
    endtask

    task automatic wait_valid();
        int ok = 0;
        for (int i = 0; i < 40 && ok == 0; i++) begin
            tick();
            if (bus.out_valid) ok = 1;
        end
        chk("out_valid_seen", ok, 1);
    endtask

    task automatic serve(input int ch, input int v);
        bus.bin_in[8*ch +: 8] = 8'(v);
        bus.req[ch] = 1'b1;
        wait_grant(ch);
        bus.req[ch] = 1'b0;
        wait_valid();
        tick();
    endtask

    task automatic chk_digits(input string name, input int h, input int t, input int o);
        chk({name, "_h"}, int'(bus.hundreds), h);
        chk({name, "_t"}, int'(bus.tens), t);
        chk({name, "_o"}, int'(bus.ones), o);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int last_cyc;
        int cnt;
        int exp_id[5]  = '{0, 1, 2, 3, 0};
        int exp_ten[5] = '{1, 2, 3, 4, 1};

        bus.req    = '0;
        bus.bin_in = '0;
        do_reset();

        // 1: 255 on ch0
        bus.bin_in[7:0] = 8'd255;
        bus.req[0] = 1'b1;
        tick();
        chk("t1_grant", int'(bus.grant), 1);
        chk("t1_busy", int'(bus.busy), 1);
        bus.req[0] = 1'b0;
        repeat (7) tick();
        chk("t1_early_valid", int'(bus.out_valid), 0);
        tick();
        chk("t1_valid", int'(bus.out_valid), 1);
        chk("t1_id", int'(bus.out_id), 0);
        chk_digits("t1", 2, 5, 5);
        tick();
        chk("t1_grant_end", int'(bus.grant), 0);
        chk("t1_busy_end", int'(bus.busy), 0);
        chk("t1_valid_end", int'(bus.out_valid), 0);

        // 3: all four requesting from reset release
        resetn = 1'b0;
        bus.req = '1;
        bus.bin_in = 32'h281E140A;
        tick();
        tick();
        resetn = 1'b1;
        last_cyc = 0;
        for (int i = 0; i < 5; i++) begin
            wait_valid();
            if (i == 4) bus.req = '0;
            chk($sformatf("t3_id%0d", i), int'(bus.out_id), exp_id[i]);
            chk_digits($sformatf("t3_r%0d", i), 0, exp_ten[i], 0);
            if (i > 0) chk("t3_gap", cyc - last_cyc, 10);
            last_cyc = cyc;
        end
        tick();
        tick();

        // 4: pointer after ch2 served
        serve(2, 77);
        bus.bin_in[15:8]  = 8'd11;
        bus.bin_in[31:24] = 8'd33;
        bus.req[1] = 1'b1;
        bus.req[3] = 1'b1;
        tick();
        chk("t4_first", int'(bus.grant), 8);
        bus.req[3] = 1'b0;
        wait_grant(1);
        chk("t4_second", int'(bus.grant), 2);
        bus.req[1] = 1'b0;
        wait_valid();
        chk("t4_id", int'(bus.out_id), 1);
        chk_digits("t4", 0, 1, 1);
        tick();

        // 2: exhaustive on ch1
        for (int v = 0; v < 256; v++) begin
            serve(1, v);
            chk("t2_value", int'(bus.hundreds) * 100 + int'(bus.tens) * 10 + int'(bus.ones), v);
            if (v == 199) chk_digits("t2_199", 1, 9, 9);
            if (v == 10) chk_digits("t2_10", 0, 1, 0);
        end

        // 5: bin_in sampled only at grant
        bus.bin_in[7:0] = 8'd123;
        bus.req[0] = 1'b1;
        wait_grant(0);
        tick();
        bus.bin_in[7:0] = 8'd77;
        bus.req[0] = 1'b0;
        wait_valid();
        chk("t5_id", int'(bus.out_id), 0);
        chk_digits("t5", 1, 2, 3);
        tick();
        cnt = 0;
        repeat (20) begin
            tick();
            if (bus.grant != '0) cnt++;
        end
        chk("t5_no_regrant", cnt, 0);

        // 6: reset during the 4th shift cycle
        bus.bin_in[23:16] = 8'd200;
        bus.req[2] = 1'b1;
        wait_grant(2);
        bus.req[2] = 1'b0;
        repeat (3) tick();
        #1 resetn = 1'b0;
        #1;
        chk("t6_grant", int'(bus.grant), 0);
        chk("t6_busy", int'(bus.busy), 0);
        chk("t6_valid", int'(bus.out_valid), 0);
        chk_digits("t6_rst", 0, 0, 0);
        tick();
        tick();
        resetn = 1'b1;
        cnt = 0;
        repeat (15) begin
            tick();
            if (bus.out_valid) cnt++;
        end
        chk("t6_no_valid", cnt, 0);
        serve(0, 42);
        chk_digits("t6_42", 0, 4, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bcd_conv_arbiter.md
Name: bcd_conv_arbiter

Overview:
Shares one iterative shift-add-3 (double-dabble) binary-to-BCD engine between NREQ requesters. Each requester presents an 8-bit value, for example a speed or distance readout. A round-robin arbiter grants one requester at a time. The engine converts the value in 8 clocks and returns hundreds/tens/ones with a one-cycle valid strobe and the requester id. It sits between the sensor/counter logic and the 7-segment display drivers, replacing one combinational converter per channel.

Parameters:
NREQ, 4, number of requesters; legal range 2..4. Id field is fixed at 2 bits.

Ports:
clk  in  1  system clock; all state updates on rising edge
resetn  in  1  asynchronous active-low reset
req  in  NREQ  per-requester level request; held high until the matching grant bit is seen
bin_in  in  8*NREQ  flattened values; requester i uses bits [8i+7:8i]
grant  out  NREQ  one-hot registered grant, high for the whole service window
busy  out  1  high whenever state is not IDLE
out_valid  out  1  one-cycle strobe; result fields valid in this cycle
out_id  out  2  index of the requester whose result is presented
hundreds  out  4  BCD hundreds digit, 0..2
tens  out  4  BCD tens digit, 0..9
ones  out  4  BCD ones digit, 0..9

Behaviour:
- Reset (resetn low, asynchronous):
  - state=IDLE; grant=0; busy=0; out_valid=0; out_id=0.
  - hundreds/tens/ones=0; round-robin pointer=0; shift counter=0; internal shift registers=0.
  - Reset mid-conversion aborts the conversion. No out_valid is produced for it. The pointer returns to 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If any req bit is high at edge E0, select the first requester with req high, scanning from pointer upward with wrap.
  - Set that grant bit, latch its bin_in slice and id, clear the BCD working regs and counter, and go to SHIFT.
  - If no req is high, stay in IDLE.
- SHIFT, one iteration per clock at edges E1..E8:
  - Add 3 to each working digit that is >= 5.
  - Then shift {H,T,O,value} left by 1, consuming the latched value MSB first.
  - Digit arithmetic is 4-bit; the add-3 rule guarantees no overflow. Hundreds never exceeds 2.
  - At E8 the counter reaches 7 and the FSM goes to DONE.
- DONE, the cycle after E8:
  - out_valid=1.
  - hundreds/tens/ones/out_id carry the new result. They are registered at E8 and hold until the next result is registered.
  - grant stays high through this cycle.
- At E9: go to IDLE, clear grant and out_valid, set pointer = (served id + 1) mod NREQ.
- Latency and throughput:
  - Grant is visible after E0. out_valid is high 9 clocks after E0.
  - The earliest next grant edge is E10, giving throughput of one conversion per 10 clocks.
- Requester rules:
  - bin_in is sampled only at E0. Changes after grant have no effect.
  - Deasserting req after E0 does not cancel the conversion.
  - req is level-sensitive. A requester still asserting req after its result is served again, but only in round-robin order.
- Boundary conditions:
  - With multiple simultaneous requests, exactly one grant bit is ever high.
  - req bits at indices >= NREQ do not exist.
  - Pointer wraps from NREQ-1 to 0.
  - Value 0 converts to 0/0/0 with normal latency; there is no early exit.

Test Plan:
1. Value 255 on ch0 only, req[0] high:
   - grant=0001 after E0 and busy high.
   - out_valid 9 clocks later with H=2, T=5, O=5, out_id=0.
   - grant=0 and busy=0 after E9.
2. Exhaustive check on ch1, values 0..255:
   - Every result equals the decimal digits, e.g. 0 gives 0/0/0, 9 gives 0/0/9, 10 gives 0/1/0, 99 gives 0/9/9, 100 gives 1/0/0, 199 gives 1/9/9.
   - out_valid is exactly one cycle wide each time.
3. All four req held high from reset release, values 10/20/30/40:
   - out_id sequence is 0,1,2,3,0 with results 0/1/0, 0/2/0, 0/3/0, 0/4/0, 0/1/0.
   - out_valid strobes are 10 clocks apart.
4. Pointer check:
   - After ch2 is served, raise req[1] and req[3] in the same cycle.
   - ch3 is granted first, then ch1.
5. Sampling check:
   - Grant ch0 with value 123, then change bin_in[7:0] to 77 and drop req[0] one cycle after grant.
   - Result is 1/2/3 with out_id=0, and no second grant occurs.
6. Reset mid-conversion:
   - Pull resetn low during the 4th SHIFT cycle. grant, busy and out_valid go to 0 without waiting for a clock edge, and the digit outputs read 0.
   - No out_valid follows reset release.
   - A fresh request for 42 then returns 0/4/2.
